// File: rtl/qed_dup_scheduler.sv
// qed_dup_scheduler: issue scheduler for QED duplicated execution.
// Originals pass to the core and are queued; queued copies are later issued
// as duplicates remapped to the x17-x31 register half and the +1024 memory half.
module qed_dup_scheduler #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        exec_dup,
  input  logic [31:0] ifu_instr,
  input  logic        ifu_valid,
  output logic        ifu_ready,
  input  logic        core_stall,
  output logic [31:0] out_instr,
  output logic        out_valid,
  output logic        out_is_dup,
  output logic [15:0] num_orig,
  output logic [15:0] num_dup,
  output logic        qed_ready,
  output logic        q_full,
  output logic        q_empty
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  typedef enum logic [1:0] {S_BYPASS, S_RUN, S_FLUSH} state_t;

  state_t        state, state_n;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, cnt_n;
  logic [15:0]   orig_n, dup_n;
  logic          qed_n;
  logic          dup_sel, do_push, do_pop, enter_run;
  logic [31:0]   head, oi_n;
  logic          ov_n, od_n;

  // Register-half map: x0 stays x0, everything else lands in x16-x31.
  function automatic logic [4:0] map_r(input logic [4:0] r);
    return (r == 5'd0) ? 5'd0 : {1'b1, r[3:0]};
  endfunction

  // Duplicate rewrite; instr[30] on loads/stores moves the address up by 1024.
  function automatic logic [31:0] remap(input logic [31:0] i);
    logic [31:0] o;
    o = i;
    case (i[6:0])
      7'b0110011, 7'b0111011: begin
        o[11:7]  = map_r(i[11:7]);
        o[19:15] = map_r(i[19:15]);
        o[24:20] = map_r(i[24:20]);
      end
      7'b0010011, 7'b0011011: begin
        if (i != NOP) begin
          o[11:7]  = map_r(i[11:7]);
          o[19:15] = map_r(i[19:15]);
        end
      end
      7'b0000011: begin
        o[11:7] = map_r(i[11:7]);
        o[30]   = 1'b1;
      end
      7'b0100011: begin
        o[24:20] = map_r(i[24:20]);
        o[30]    = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  assign q_full  = (count == FULL_CNT);
  assign q_empty = (count == '0);
  assign head    = mem[rd_ptr];

  // A full queue always forces a duplicate so fetch can never deadlock it.
  assign dup_sel   = (state == S_RUN) && !q_empty && (exec_dup || q_full);
  assign do_push   = !core_stall && (state == S_RUN) && !dup_sel && ifu_valid;
  assign do_pop    = !core_stall && (dup_sel || ((state == S_FLUSH) && !q_empty));
  assign enter_run = !core_stall && (state == S_BYPASS) && ena;
  assign ifu_ready = !core_stall && ((state == S_BYPASS) || ((state == S_RUN) && !dup_sel));

  // Next-state values for FSM, counters, queue occupancy and the check point.
  always_comb begin
    state_n = state;
    orig_n  = num_orig;
    dup_n   = num_dup;
    cnt_n   = count;
    if (!core_stall) begin
      case (state)
        S_BYPASS: begin
          if (ena) begin
            state_n = S_RUN;
            orig_n  = '0;
            dup_n   = '0;
            cnt_n   = '0;
          end
        end
        S_RUN: begin
          if (!ena) state_n = S_FLUSH;
        end
        S_FLUSH: begin
          if (count <= ONE_CNT) state_n = S_BYPASS;
        end
        default: state_n = S_BYPASS;
      endcase
      if (do_push) begin
        orig_n = num_orig + 16'd1;
        cnt_n  = count + ONE_CNT;
      end else if (do_pop) begin
        dup_n = num_dup + 16'd1;
        cnt_n = count - ONE_CNT;
      end
    end
    // Gated on the state issuing this cycle, so the last flush pop still flags.
    qed_n = ((state == S_RUN) || (state == S_FLUSH)) &&
            (orig_n == dup_n) && (orig_n != 16'd0) && (cnt_n == '0);
  end

  // Next values of the registered issue port.
  always_comb begin
    oi_n = NOP;
    ov_n = 1'b0;
    od_n = 1'b0;
    case (state)
      S_BYPASS: begin
        oi_n = ifu_valid ? ifu_instr : NOP;
        ov_n = ifu_valid;
      end
      S_RUN, S_FLUSH: begin
        if (do_pop) begin
          oi_n = remap(head);
          ov_n = 1'b1;
          od_n = 1'b1;
        end else if (do_push) begin
          oi_n = ifu_instr;
          ov_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Queue storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= ifu_instr;
  end

  // Control state, pointers, counters and registered outputs; stall freezes all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_BYPASS;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      num_orig   <= '0;
      num_dup    <= '0;
      qed_ready  <= 1'b0;
      out_instr  <= NOP;
      out_valid  <= 1'b0;
      out_is_dup <= 1'b0;
    end else if (!core_stall) begin
      state      <= state_n;
      count      <= cnt_n;
      num_orig   <= orig_n;
      num_dup    <= dup_n;
      qed_ready  <= qed_n;
      out_instr  <= oi_n;
      out_valid  <= ov_n;
      out_is_dup <= od_n;
      if (enter_run) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// tb_qed_dup_scheduler: directed scenarios with hand-computed expectations.
module tb_qed_dup_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, ena, exec_dup, ifu_valid, core_stall;
  logic [31:0] ifu_instr;
  logic        ifu_ready, out_valid, out_is_dup, qed_ready, q_full, q_empty;
  logic [31:0] out_instr;
  logic [15:0] num_orig, num_dup;

  int checks = 0;
  int failures = 0;

  logic [31:0] t3_orig [5] = '{32'h00802283, 32'h00000013, 32'h00502223, 32'h00518213, 32'h000010B7};
  logic [31:0] t3_dup  [5] = '{32'h40802A83, 32'h00000013, 32'h41502223, 32'h00598A13, 32'h000010B7};
  logic [31:0] add_dup [3] = '{32'h000008B3, 32'h00000933, 32'h000009B3};

  qed_dup_scheduler #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .exec_dup(exec_dup),
    .ifu_instr(ifu_instr), .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
    .core_stall(core_stall), .out_instr(out_instr), .out_valid(out_valid),
    .out_is_dup(out_is_dup), .num_orig(num_orig), .num_dup(num_dup),
    .qed_ready(qed_ready), .q_full(q_full), .q_empty(q_empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_to_run();
    rst_n = 0; ena = 0; ifu_valid = 0; exec_dup = 0; core_stall = 0;
    step();
    rst_n = 1; ena = 1;
    step();
  endtask

  task automatic push_adds(input int n);
    for (int i = 0; i < n; i++) begin
      ifu_valid = 1; exec_dup = 0;
      ifu_instr = 32'h00000033 | ((i + 1) << 7);
      #1;
      checks++; if (ifu_ready !== 1'b1) begin failures++; $display("FAIL push_ready[%0d] got=%b exp=1", i, ifu_ready); end
      step();
    end
    ifu_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; ena = 0; exec_dup = 0; ifu_valid = 0; core_stall = 0; ifu_instr = 32'h0;
    step(); step();
    checks++; if (out_instr !== 32'h00000013) begin failures++; $display("FAIL rst_instr got=%h exp=00000013", out_instr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (q_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", q_empty); end
    checks++; if ({num_orig, num_dup} !== 32'h0) begin failures++; $display("FAIL rst_counts got=%h/%h exp=0/0", num_orig, num_dup); end
    checks++; if (qed_ready !== 1'b0) begin failures++; $display("FAIL rst_qed got=%b exp=0", qed_ready); end
  endtask

  task automatic test_bypass();
    rst_n = 1; ena = 0; ifu_valid = 1; ifu_instr = 32'hDEADBEEF;
    #1;
    checks++; if (ifu_ready !== 1'b1) begin failures++; $display("FAIL byp_ready got=%b exp=1", ifu_ready); end
    step();
    checks++; if ({out_instr, out_valid, out_is_dup} !== {32'hDEADBEEF, 2'b10}) begin failures++; $display("FAIL byp_pass got=%h/%b/%b exp=deadbeef/1/0", out_instr, out_valid, out_is_dup); end
    ifu_valid = 0;
    step();
    checks++; if ({out_instr, out_valid} !== {32'h00000013, 1'b0}) begin failures++; $display("FAIL byp_idle got=%h/%b exp=00000013/0", out_instr, out_valid); end
  endtask

  task automatic test_r_type();
    ena = 1; ifu_valid = 0;
    step();
    ifu_valid = 1; exec_dup = 0; ifu_instr = 32'h002081B3;
    #1;
    checks++; if (ifu_ready !== 1'b1) begin failures++; $display("FAIL r_ready got=%b exp=1", ifu_ready); end
    step();
    checks++; if ({out_instr, out_valid, out_is_dup} !== {32'h002081B3, 2'b10}) begin failures++; $display("FAIL r_orig got=%h/%b/%b exp=002081b3/1/0", out_instr, out_valid, out_is_dup); end
    checks++; if ({num_orig, num_dup, qed_ready} !== {16'd1, 16'd0, 1'b0}) begin failures++; $display("FAIL r_cnt1 got=%0d/%0d/%b exp=1/0/0", num_orig, num_dup, qed_ready); end
    ifu_valid = 0; exec_dup = 1;
    #1;
    checks++; if (ifu_ready !== 1'b0) begin failures++; $display("FAIL r_dup_ready got=%b exp=0", ifu_ready); end
    step();
    checks++; if ({out_instr, out_valid, out_is_dup} !== {32'h012889B3, 2'b11}) begin failures++; $display("FAIL r_dup got=%h/%b/%b exp=012889b3/1/1", out_instr, out_valid, out_is_dup); end
    checks++; if ({num_dup, qed_ready, q_empty} !== {16'd1, 2'b11}) begin failures++; $display("FAIL r_qed got=%0d/%b/%b exp=1/1/1", num_dup, qed_ready, q_empty); end
  endtask

  task automatic test_remap_kinds();
    for (int i = 0; i < 5; i++) begin
      exec_dup = 0; ifu_valid = 1; ifu_instr = t3_orig[i];
      step();
      checks++; if ({out_instr, out_is_dup} !== {t3_orig[i], 1'b0}) begin failures++; $display("FAIL kind_orig[%0d] got=%h/%b exp=%h/0", i, out_instr, out_is_dup, t3_orig[i]); end
    end
    checks++; if (num_orig !== 16'd6) begin failures++; $display("FAIL kind_norig got=%0d exp=6", num_orig); end
    ifu_valid = 0; exec_dup = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({out_instr, out_valid, out_is_dup} !== {t3_dup[i], 2'b11}) begin failures++; $display("FAIL kind_dup[%0d] got=%h/%b/%b exp=%h/1/1", i, out_instr, out_valid, out_is_dup, t3_dup[i]); end
      checks++; if (qed_ready !== (i == 4)) begin failures++; $display("FAIL kind_qed[%0d] got=%b exp=%b", i, qed_ready, (i == 4)); end
    end
    checks++; if ({num_dup, q_empty} !== {16'd6, 1'b1}) begin failures++; $display("FAIL kind_ndup got=%0d/%b exp=6/1", num_dup, q_empty); end
    exec_dup = 0;
  endtask

  task automatic test_queue_full();
    reset_to_run();
    push_adds(8);
    checks++; if ({q_full, num_orig} !== {1'b1, 16'd8}) begin failures++; $display("FAIL full_flag got=%b/%0d exp=1/8", q_full, num_orig); end
    ifu_valid = 1; exec_dup = 0; ifu_instr = 32'h00000433;
    #1;
    checks++; if (ifu_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ifu_ready); end
    step();
    checks++; if ({out_instr, out_is_dup} !== {32'h000008B3, 1'b1}) begin failures++; $display("FAIL full_forced got=%h/%b exp=000008b3/1", out_instr, out_is_dup); end
    checks++; if ({num_orig, num_dup, q_full} !== {16'd8, 16'd1, 1'b0}) begin failures++; $display("FAIL full_cnt got=%0d/%0d/%b exp=8/1/0", num_orig, num_dup, q_full); end
    ifu_valid = 0;
  endtask

  task automatic test_flush();
    reset_to_run();
    push_adds(3);
    ena = 0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_enter got=%b exp=0", out_valid); end
    ena = 1; ifu_valid = 1; ifu_instr = 32'h00000533;
    #1;
    checks++; if (ifu_ready !== 1'b0) begin failures++; $display("FAIL fl_ready got=%b exp=0", ifu_ready); end
    step();
    checks++; if ({out_instr, out_is_dup, num_dup} !== {add_dup[0], 1'b1, 16'd1}) begin failures++; $display("FAIL fl_dup0 got=%h/%b/%0d exp=%h/1/1", out_instr, out_is_dup, num_dup, add_dup[0]); end
    core_stall = 1;
    #1;
    checks++; if (ifu_ready !== 1'b0) begin failures++; $display("FAIL fl_stall_ready got=%b exp=0", ifu_ready); end
    step();
    checks++; if ({out_instr, out_is_dup, num_dup} !== {add_dup[0], 1'b1, 16'd1}) begin failures++; $display("FAIL fl_stall_hold got=%h/%b/%0d exp=%h/1/1", out_instr, out_is_dup, num_dup, add_dup[0]); end
    core_stall = 0;
    step();
    checks++; if ({out_instr, qed_ready} !== {add_dup[1], 1'b0}) begin failures++; $display("FAIL fl_dup1 got=%h/%b exp=%h/0", out_instr, qed_ready, add_dup[1]); end
    step();
    checks++; if ({out_instr, qed_ready, q_empty} !== {add_dup[2], 2'b11}) begin failures++; $display("FAIL fl_dup2 got=%h/%b/%b exp=%h/1/1", out_instr, qed_ready, q_empty, add_dup[2]); end
    checks++; if ({num_orig, num_dup} !== {16'd3, 16'd3}) begin failures++; $display("FAIL fl_cnt got=%0d/%0d exp=3/3", num_orig, num_dup); end
    ena = 0; ifu_valid = 1; ifu_instr = 32'hCAFE0037;
    #1;
    checks++; if (ifu_ready !== 1'b1) begin failures++; $display("FAIL fl_byp_ready got=%b exp=1", ifu_ready); end
    step();
    checks++; if ({out_instr, out_valid, out_is_dup, qed_ready} !== {32'hCAFE0037, 3'b100}) begin failures++; $display("FAIL fl_byp got=%h/%b/%b/%b exp=cafe0037/1/0/0", out_instr, out_valid, out_is_dup, qed_ready); end
    ifu_valid = 0;
  endtask

  task automatic test_reset_mid_run();
    reset_to_run();
    push_adds(4);
    checks++; if (num_orig !== 16'd4) begin failures++; $display("FAIL mr_pre got=%0d exp=4", num_orig); end
    rst_n = 0;
    step();
    checks++; if ({q_empty, num_orig, num_dup} !== {1'b1, 32'h0}) begin failures++; $display("FAIL mr_state got=%b/%0d/%0d exp=1/0/0", q_empty, num_orig, num_dup); end
    checks++; if ({out_instr, out_valid, qed_ready} !== {32'h00000013, 2'b00}) begin failures++; $display("FAIL mr_out got=%h/%b/%b exp=00000013/0/0", out_instr, out_valid, qed_ready); end
    rst_n = 1; ena = 0; ifu_valid = 1; ifu_instr = 32'h00100093;
    #1;
    checks++; if (ifu_ready !== 1'b1) begin failures++; $display("FAIL mr_byp_ready got=%b exp=1", ifu_ready); end
    step();
    checks++; if ({out_instr, out_valid, out_is_dup} !== {32'h00100093, 2'b10}) begin failures++; $display("FAIL mr_byp got=%h/%b/%b exp=00100093/1/0", out_instr, out_valid, out_is_dup); end
    ifu_valid = 0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_r_type();
    test_remap_kinds();
    test_queue_full();
    test_flush();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
